// File: rtl/tone_sequencer_if.sv
// Bus bundle for tone_sequencer: CPU register port plus the freqgen write port.
// The master side is the CPU/bench, the slave side is the sequencer.
interface tone_sequencer_if;
  logic [15:0] addr;
  logic [15:0] data;
  logic        we;
  logic [15:0] rdata;
  logic [15:0] fg_addr;
  logic [15:0] fg_data;
  logic        fg_we;

  modport master (output addr, data, we, input rdata, fg_addr, fg_data, fg_we);
  modport slave  (input addr, data, we, output rdata, fg_addr, fg_data, fg_we);
endinterface

// File: rtl/tone_sequencer.sv
// Note FIFO plus playback FSM that drives freqgen register writes autonomously.
// Define TONESEQ_LOOP_EN to build the LOOP mode with a separate play pointer.
module tone_sequencer #(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 1000
) (
  input logic              clk,
  input logic              rst,
  tone_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_LOAD, S_WR, S_PLAY, S_STOP} state_t;
  state_t state;

  logic [15:0]   period_stage;
  logic          en;
  logic [4:0]    div;
  logic [AW-1:0] head, tail;
  logic [6:0]    count;
  logic          overflow;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   entry_q;
  logic [15:0]   dur_q;
  logic [PW-1:0] presc;

`ifdef TONESEQ_LOOP_EN
  logic [AW-1:0] play_ptr;
  logic          loop;
`else
  logic [AW-1:0] play_ptr;
  logic          loop;
  assign play_ptr = head;
  assign loop     = 1'b0;
`endif

  logic wr_period, wr_dur, wr_ctrl, flush, full, empty, pop, push, tick, busy;
  logic unused_addr;

  assign wr_period   = bus.we && (bus.addr[1:0] == 2'd0);
  assign wr_dur      = bus.we && (bus.addr[1:0] == 2'd1);
  assign wr_ctrl     = bus.we && (bus.addr[1:0] == 2'd2);
  assign flush       = wr_ctrl && bus.data[2];
  assign full        = (count == 7'(DEPTH));
  assign empty       = (count == 7'd0);
  assign pop         = (state == S_LOAD) && !loop && !flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign push        = wr_dur && !flush && (!full || pop);
  assign tick        = (presc == PW'(TICK_DIV - 1));
  assign busy        = (state != S_IDLE);
  assign unused_addr = ^bus.addr[15:2];

  always_comb begin
    bus.rdata = '0;
    case (bus.addr[1:0])
      2'd3:    bus.rdata = {busy, overflow, full, empty, 5'b0, count};
      2'd2:    bus.rdata = {3'b0, div, 6'b0, loop, en};
      default: bus.rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[tail] <= {period_stage, bus.data};
    if (state == S_LOAD)
      entry_q <= mem[play_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      period_stage <= '0;
      en           <= 1'b0;
      div          <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      dur_q        <= '0;
      presc        <= '0;
      bus.fg_we    <= 1'b0;
      bus.fg_addr  <= '0;
      bus.fg_data  <= '0;
`ifdef TONESEQ_LOOP_EN
      play_ptr     <= '0;
      loop         <= 1'b0;
`endif
    end else begin
      bus.fg_we <= 1'b0;
      if (wr_period)
        period_stage <= bus.data;
      if (wr_ctrl) begin
        en  <= bus.data[0];
        div <= bus.data[12:8];
`ifdef TONESEQ_LOOP_EN
        loop <= bus.data[1];
`endif
      end

      if (flush) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        overflow <= 1'b0;
`ifdef TONESEQ_LOOP_EN
        play_ptr <= '0;
`endif
      end else begin
        if (push)
          tail <= tail + AW'(1);
        else if (wr_dur)
          overflow <= 1'b1;
        if (pop)
          head <= head + AW'(1);
`ifdef TONESEQ_LOOP_EN
        if (state == S_LOAD) begin
          if (pop || (play_ptr + AW'(1) != tail))
            play_ptr <= play_ptr + AW'(1);
          else
            play_ptr <= head;
        end
`endif
        case ({push, pop})
          2'b10:   count <= count + 7'd1;
          2'b01:   count <= count - 7'd1;
          default: count <= count;
        endcase
      end

      case (state)
        S_IDLE: if (en && !empty && !flush) state <= S_DIV;
        S_DIV: begin
          if (flush) state <= S_STOP;
          else begin
            bus.fg_we   <= 1'b1;
            bus.fg_addr <= 16'd0;
            bus.fg_data <= {11'b0, div};
            state       <= S_LOAD;
          end
        end
        S_LOAD: state <= flush ? S_STOP : S_WR;
        S_WR: begin
          if (flush) state <= S_STOP;
          else begin
            bus.fg_we   <= 1'b1;
            bus.fg_addr <= 16'd3;
            bus.fg_data <= entry_q[31:16];
            dur_q       <= (entry_q[15:0] == 16'd0) ? 16'd1 : entry_q[15:0];
            presc       <= '0;
            state       <= S_PLAY;
          end
        end
        S_PLAY: begin
          // An expired last note lingers one cycle at dur_q==0 before the silencing write.
          if (flush || !en || (dur_q == 16'd0))
            state <= S_STOP;
          else if (tick) begin
            presc <= '0;
            dur_q <= dur_q - 16'd1;
            if ((dur_q == 16'd1) && (count != 7'd0))
              state <= S_LOAD;
          end else
            presc <= presc + PW'(1);
        end
        S_STOP: begin
          bus.fg_we   <= 1'b1;
          bus.fg_addr <= 16'd3;
          bus.fg_data <= 16'd0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer (DEPTH=8, TICK_DIV=4); logs every freqgen write.
module tb_tone_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_wr = 0;

  tone_sequencer_if bus ();

  tone_sequencer #(.DEPTH(8), .TICK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          log_cyc[$];
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];

  always @(negedge clk) begin
    if (bus.fg_we === 1'b1) begin
      log_cyc.push_back(cyc);
      log_addr.push_back(bus.fg_addr);
      log_data.push_back(bus.fg_data);
      $display("fg write cyc=%0d addr=%0d data=%0d", cyc, bus.fg_addr, bus.fg_data);
    end
  end

  task automatic clear_log();
    log_cyc.delete(); log_addr.delete(); log_data.delete();
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr = {14'b0, a}; bus.data = d; bus.we = 1'b1;
    @(negedge clk);
    #1;
    bus.we = 1'b0;
    last_wr = cyc;
    $display("cpu write cyc=%0d addr=%0d data=0x%04h", cyc, a, d);
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [15:0] v);
    @(negedge clk);
    bus.addr = {14'b0, a};
    #1;
    v = bus.rdata;
    $display("cpu read  cyc=%0d addr=%0d data=0x%04h", cyc, a, v);
  endtask

  task automatic push_note(input logic [15:0] per, input logic [15:0] dur);
    cpu_write(2'd0, per);
    cpu_write(2'd1, dur);
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_cyc.size() < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    checks++;
    if (log_cyc.size() < n) begin
      failures++;
      $display("FAIL %s timeout: writes=%0d required=%0d", name, log_cyc.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.fg_we !== 1'b0) begin failures++; $display("FAIL reset_fg_we got %b expected 0", bus.fg_we); end
    checks++; if (bus.fg_addr !== 16'd0) begin failures++; $display("FAIL reset_fg_addr got %0d expected 0", bus.fg_addr); end
    checks++; if (bus.fg_data !== 16'd0) begin failures++; $display("FAIL reset_fg_data got %0d expected 0", bus.fg_data); end
    cpu_read(2'd3, v);
    checks++; if (v !== 16'h1000) begin failures++; $display("FAIL reset_status got %h expected 1000", v); end
    cpu_read(2'd2, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL reset_ctrl got %h expected 0000", v); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single();
    logic [15:0] v;
    int t0;
    clear_log();
    push_note(16'd100, 16'd5);
    cpu_write(2'd2, 16'h0301);
    t0 = last_wr;
    wait_log(3, 200, "single_writes");
    checks++; if (log_addr[0] !== 16'd0 || log_data[0] !== 16'd3) begin failures++; $display("FAIL single_div got (%0d,%0d) expected (0,3)", log_addr[0], log_data[0]); end
    checks++; if (log_cyc[0] - t0 !== 2) begin failures++; $display("FAIL single_div_latency got %0d expected 2", log_cyc[0] - t0); end
    checks++; if (log_addr[1] !== 16'd3 || log_data[1] !== 16'd100) begin failures++; $display("FAIL single_wr got (%0d,%0d) expected (3,100)", log_addr[1], log_data[1]); end
    checks++; if (log_cyc[1] - t0 !== 4) begin failures++; $display("FAIL single_wr_latency got %0d expected 4", log_cyc[1] - t0); end
    checks++; if (log_addr[2] !== 16'd3 || log_data[2] !== 16'd0) begin failures++; $display("FAIL single_stop got (%0d,%0d) expected (3,0)", log_addr[2], log_data[2]); end
    checks++; if (log_cyc[2] - log_cyc[1] !== 22) begin failures++; $display("FAIL single_hold got %0d expected 22", log_cyc[2] - log_cyc[1]); end
    repeat (3) @(negedge clk);
    cpu_read(2'd3, v);
    checks++; if (v !== 16'h1000) begin failures++; $display("FAIL single_idle_status got %h expected 1000", v); end
  endtask

  task automatic test_queue();
    logic [15:0] v;
    logic [15:0] exp_data [5];
    int exp_gap [4];
    exp_data = '{16'd3, 16'd10, 16'd0, 16'd20, 16'd0};
    exp_gap  = '{2, 10, 6, 14};
    clear_log();
    push_note(16'd10, 16'd2);
    push_note(16'd0, 16'd1);
    push_note(16'd20, 16'd3);
    wait_log(5, 300, "queue_writes");
    repeat (20) @(negedge clk);
    checks++; if (log_cyc.size() !== 5) begin failures++; $display("FAIL queue_write_count got %0d expected 5", log_cyc.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (log_data[i] !== exp_data[i]) begin failures++; $display("FAIL queue_data[%0d] got %0d expected %0d", i, log_data[i], exp_data[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      checks++; if (log_cyc[i+1] - log_cyc[i] !== exp_gap[i]) begin failures++; $display("FAIL queue_hold[%0d] got %0d expected %0d", i, log_cyc[i+1] - log_cyc[i], exp_gap[i]); end
    end
    cpu_read(2'd3, v);
    checks++; if (v !== 16'h1000) begin failures++; $display("FAIL queue_status got %h expected 1000", v); end
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    cpu_write(2'd2, 16'h0000);
    for (int i = 1; i <= 9; i++) push_note(16'(i * 11), 16'(i));
    cpu_read(2'd3, v);
    checks++; if (v !== 16'h6008) begin failures++; $display("FAIL overflow_status got %h expected 6008", v); end
    cpu_write(2'd2, 16'h0004);
    cpu_read(2'd3, v);
    checks++; if (v !== 16'h1000) begin failures++; $display("FAIL flush_status got %h expected 1000", v); end
    cpu_read(2'd2, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL flush_ctrl got %h expected 0000", v); end
  endtask

  task automatic test_en_abort();
    logic [15:0] v;
    int t0;
    clear_log();
    push_note(16'd30, 16'd50);
    push_note(16'd40, 16'd1);
    push_note(16'd50, 16'd1);
    cpu_write(2'd2, 16'h0101);
    wait_log(2, 50, "abort_start");
    checks++; if (log_data[0] !== 16'd1 || log_data[1] !== 16'd30) begin failures++; $display("FAIL abort_start got (%0d,%0d) expected (1,30)", log_data[0], log_data[1]); end
    repeat (10) @(negedge clk);
    cpu_write(2'd2, 16'h0100);
    t0 = last_wr;
    wait_log(3, 20, "abort_stop");
    checks++; if (log_addr[2] !== 16'd3 || log_data[2] !== 16'd0) begin failures++; $display("FAIL abort_stop got (%0d,%0d) expected (3,0)", log_addr[2], log_data[2]); end
    checks++; if (log_cyc[2] - t0 > 2 || log_cyc[2] - t0 < 1) begin failures++; $display("FAIL abort_latency got %0d expected 1..2", log_cyc[2] - t0); end
    repeat (3) @(negedge clk);
    cpu_read(2'd3, v);
    checks++; if (v !== 16'h0002) begin failures++; $display("FAIL abort_status got %h expected 0002", v); end
    cpu_write(2'd2, 16'h0004);
  endtask

`ifdef TONESEQ_LOOP_EN
  task automatic test_loop();
    logic [15:0] v;
    int n0;
    clear_log();
    push_note(16'd7, 16'd1);
    push_note(16'd9, 16'd1);
    cpu_write(2'd2, 16'h0003);
    wait_log(7, 200, "loop_writes");
    for (int i = 1; i < 7; i++) begin
      checks++; if (log_data[i] !== ((i % 2 == 1) ? 16'd7 : 16'd9)) begin failures++; $display("FAIL loop_data[%0d] got %0d expected %0d", i, log_data[i], (i % 2 == 1) ? 7 : 9); end
    end
    cpu_read(2'd3, v);
    checks++; if (v !== 16'h8002) begin failures++; $display("FAIL loop_status got %h expected 8002", v); end
    cpu_write(2'd2, 16'h0007);
    n0 = log_cyc.size();
    repeat (20) @(negedge clk);
    checks++; if (log_cyc.size() !== n0 + 1) begin failures++; $display("FAIL loop_flush_writes got %0d expected %0d", log_cyc.size(), n0 + 1); end
    checks++; if (log_addr[$] !== 16'd3 || log_data[$] !== 16'd0) begin failures++; $display("FAIL loop_flush_stop got (%0d,%0d) expected (3,0)", log_addr[$], log_data[$]); end
    cpu_read(2'd3, v);
    checks++; if (v !== 16'h1000) begin failures++; $display("FAIL loop_flush_status got %h expected 1000", v); end
    cpu_write(2'd2, 16'h0000);
  endtask
`else
  task automatic test_loop();
    logic [15:0] v;
    cpu_write(2'd2, 16'h0003);
    cpu_read(2'd2, v);
    checks++; if (v !== 16'h0001) begin failures++; $display("FAIL loop_bit_absent got %h expected 0001", v); end
    cpu_write(2'd2, 16'h0000);
  endtask
`endif

  task automatic test_reset_play();
    logic [15:0] v;
    clear_log();
    push_note(16'd55, 16'd50);
    cpu_write(2'd2, 16'h0101);
    wait_log(2, 50, "rstplay_start");
    checks++; if (log_data[1] !== 16'd55) begin failures++; $display("FAIL rstplay_wr got %0d expected 55", log_data[1]); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.fg_we !== 1'b0 || bus.fg_addr !== 16'd0 || bus.fg_data !== 16'd0) begin failures++; $display("FAIL rstplay_outputs got we=%b addr=%0d data=%0d expected 0,0,0", bus.fg_we, bus.fg_addr, bus.fg_data); end
    cpu_read(2'd3, v);
    checks++; if (v !== 16'h1000) begin failures++; $display("FAIL rstplay_status got %h expected 1000", v); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (log_cyc.size() !== 2) begin failures++; $display("FAIL rstplay_no_stop got %0d writes expected 2", log_cyc.size()); end
  endtask

  initial begin
    bus.addr = '0; bus.data = '0; bus.we = 1'b0;
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_en_abort();
    test_loop();
    test_reset_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
